rc5_decrypt_core: RTL



---
 rtl/rc5_decrypt_core.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rc5_decrypt_core.sv
// Iterative RC5-16/r/b decryption engine: one full round per clock, loadable
// 34-entry subkey table, start/done handshake.
module rc5_decrypt_core #(
  parameter int unsigned W          = 16,
  parameter int unsigned MAX_ROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       num_rounds,
  input  logic [2*W-1:0]   d_in,
  input  logic             sk_we,
  input  logic [5:0]       sk_addr,
  input  logic [W-1:0]     sk_data,
  output logic [2*W-1:0]   d_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SK_N = 2 * (MAX_ROUNDS + 1);
  localparam int unsigned LG   = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [4:0]       r_cnt;
  logic [2*W-1:0]   r_d_out;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_sk [SK_N];

  logic [4:0]       w_cnt_ld;
  logic [5:0]       w_idx;
  logic [W-1:0]     w_b_new;
  logic [W-1:0]     w_a_new;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LG-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  assign w_cnt_ld = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;
  assign w_idx    = {r_cnt, 1'b0};

  // Inverse round: B is undone first, then A using the recovered B.
  always_comb begin
    w_b_new = rotr(r_b - r_sk[w_idx + 6'd1], r_a[LG-1:0]) ^ r_a;
    w_a_new = rotr(r_a - r_sk[w_idx], w_b_new[LG-1:0]) ^ w_b_new;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = (w_cnt_ld != 5'd0) ? ROUND : FINAL;
      ROUND: if (r_cnt == 5'd1) w_state_nxt = FINAL;
      FINAL: w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_d_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a   <= d_in[W-1:0];
          r_b   <= d_in[2*W-1:W];
          r_cnt <= w_cnt_ld;
        end
        ROUND: begin
          r_a   <= w_a_new;
          r_b   <= w_b_new;
          r_cnt <= r_cnt - 5'd1;
        end
        FINAL: r_d_out <= {r_b - r_sk[1], r_a - r_sk[0]};
        default: ;
      endcase
    end
  end

  // Table is writable only in IDLE so it stays stable during an operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SK_N); i++) r_sk[i] <= '0;
    end else if (r_state == IDLE && sk_we && sk_addr < 6'(SK_N)) begin
      r_sk[sk_addr] <= sk_data;
    end
  end

  assign d_out = r_d_out;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
